// File: rtl/adder56_accum_seq_pkg.sv
// Shared constants and types for the 56-bit operand-stream accumulator.
package adder56_accum_seq_pkg;

  localparam int ACC_W = 56;
  localparam int OP_W  = 15;
  localparam int CNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    DONE  = ST_DONE
  } state_t;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             ovf;
  } result_t;

endpackage

// File: rtl/adder56_accum_dp.sv
// Accumulator/overflow registers around one zero-extending ACC_W + OP_W adder.
// ADDER56_ACCUM_SATURATE_EN selects saturation instead of modulo wrap.
module adder56_accum_dp
  import adder56_accum_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             add_en,
  input  logic [ACC_W-1:0] init,
  input  logic [OP_W-1:0]  op,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc} + {{(ACC_W+1-OP_W){1'b0}}, op};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= init;
      ovf <= 1'b0;
    end else if (add_en) begin
`ifdef ADDER56_ACCUM_SATURATE_EN
      // once saturated, stay pinned at all-ones for the rest of the job
      if (sum[ACC_W] || ovf) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
`else
      acc <= sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
`endif
    end
  end

endmodule

// File: rtl/adder56_accum_seq.sv
// Sequencer: loads an initial value, accumulates N 15-bit operands, holds the result.
// Build option ADDER56_ACCUM_SATURATE_EN (in adder56_accum_dp) saturates instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; captures init_val/count on start
// ACCUM | op_ready high; one operand per transfer, remaining counts down
// DONE  | res_valid high until res_ready
module adder56_accum_seq
  import adder56_accum_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] init_val,
  input  logic [CNT_W-1:0] count,
  input  logic             op_valid,
  input  logic [OP_W-1:0]  op_data,
  output logic             op_ready,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  input  logic             res_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             load;
  logic             xfer;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  result_t          res;

  assign op_ready  = (state == ACCUM);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign load      = (state == IDLE) && start;
  assign xfer      = op_valid && op_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= count;
            state     <= (count == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  adder56_accum_dp u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .add_en (xfer),
    .init   (init_val),
    .op     (op_data),
    .acc    (acc),
    .ovf    (ovf)
  );

  // acc only moves on load/add, so res_data naturally holds outside DONE
  assign res.data = acc;
  assign res.ovf  = ovf && res_valid;
  assign res_data = res.data;
  assign res_ovf  = res.ovf;

endmodule

// File: tb/tb_adder56_accum_seq.sv
// Directed bench for adder56_accum_seq: per-cycle model compare plus literal pins.
module tb_adder56_accum_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [55:0] init_val = '0;
  logic [7:0]  count = '0;
  logic        op_valid = 1'b0;
  logic [14:0] op_data = '0;
  logic        op_ready;
  logic        res_valid;
  logic [55:0] res_data;
  logic        res_ovf;
  logic        res_ready = 1'b0;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  adder56_accum_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .init_val  (init_val),
    .count     (count),
    .op_valid  (op_valid),
    .op_data   (op_data),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_ready (res_ready),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Behavioural model: job phase, running value as a plain 64-bit sum.
  int          m_phase;   // 0 idle, 1 taking operands, 2 result held
  logic [63:0] m_acc;
  logic        m_ovf;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    logic [63:0] s;
    if (rst) begin
      m_phase = 0; m_acc = 0; m_ovf = 0; m_left = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_acc = {8'h0, init_val};
        m_ovf = 0;
        m_left = count;
        m_phase = (count == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (op_valid) begin
        s = m_acc + {49'h0, op_data};
`ifdef ADDER56_ACCUM_SATURATE_EN
        if (s >= 64'h0100_0000_0000_0000 || m_ovf) begin
          m_acc = 64'h00FF_FFFF_FFFF_FFFF;
          m_ovf = 1;
        end else begin
          m_acc = s;
        end
`else
        m_ovf = m_ovf | (s >= 64'h0100_0000_0000_0000);
        m_acc = s % 64'h0100_0000_0000_0000;
`endif
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
      end
    end else begin
      if (res_ready) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", {63'h0, busy}, {63'h0, m_phase != 0});
      chk("op_ready", {63'h0, op_ready}, {63'h0, m_phase == 1});
      chk("res_valid", {63'h0, res_valid}, {63'h0, m_phase == 2});
      chk("res_ovf", {63'h0, res_ovf}, {63'h0, (m_phase == 2) && m_ovf});
      if (m_phase == 2) chk("res_data", {8'h0, res_data}, m_acc);
    end
  end

  task automatic cyc(input bit s, input bit v, input logic [14:0] d, input bit rr);
    @(negedge clk);
    start = s; op_valid = v; op_data = d; res_ready = rr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_op_ready", {63'h0, op_ready}, 64'h0);
    chk("rst_res_valid", {63'h0, res_valid}, 64'h0);
    chk("rst_res_ovf", {63'h0, res_ovf}, 64'h0);
    chk("rst_res_data", {8'h0, res_data}, 64'h0);
    @(negedge clk); #2 rst = 1'b0;

    // abort mid-ACCUM after 2 of 5 operands
    init_val = 56'd50; count = 8'd5;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 15'd3, 0);
    cyc(0, 1, 15'd4, 0);
    cyc(0, 0, 0, 0);
    chk("abort_pre_busy", {63'h0, busy}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_op_ready", {63'h0, op_ready}, 64'h0);
    chk("abort_res_valid", {63'h0, res_valid}, 64'h0);
    @(negedge clk); #2 rst = 1'b0;
    init_val = 56'd0; count = 8'd1;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 15'd7, 0);
    cyc(0, 0, 0, 0);
    chk("after_abort_valid", {63'h0, res_valid}, 64'h1);
    chk("after_abort_data", {8'h0, res_data}, 64'd7);
    cyc(0, 0, 0, 1);

    // saturation/wrap boundary; start in same cycle as handoff is ignored
    init_val = 56'hFF_FFFF_FFFF_FFFE; count = 8'd2;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 15'd1, 0);
    cyc(0, 1, 15'd1, 0);
    cyc(0, 0, 0, 0);
`ifdef ADDER56_ACCUM_SATURATE_EN
    chk("edge_data", {8'h0, res_data}, 64'h00FF_FFFF_FFFF_FFFF);
`else
    chk("edge_data", {8'h0, res_data}, 64'h0);
`endif
    chk("edge_ovf", {63'h0, res_ovf}, 64'h1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("handoff_start_ignored", {63'h0, busy}, 64'h0);

    // back-to-back job: 100 + 1 + 2 + 3
    init_val = 56'd100; count = 8'd3;
    cyc(1, 0, 0, 1);
    cyc(0, 1, 15'd1, 1);
    cyc(0, 1, 15'd2, 1);
    cyc(0, 1, 15'd3, 1);
    cyc(0, 0, 0, 1);
    chk("sum106_valid", {63'h0, res_valid}, 64'h1);
    chk("sum106_data", {8'h0, res_data}, 64'd106);
    chk("sum106_ovf", {63'h0, res_ovf}, 64'h0);
    cyc(0, 0, 0, 1);
    chk("sum106_busy_low", {63'h0, busy}, 64'h0);

    // count == 0
    init_val = 56'hABC; count = 8'd0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("cnt0_valid", {63'h0, res_valid}, 64'h1);
    chk("cnt0_data", {8'h0, res_data}, 64'hABC);
    chk("cnt0_op_ready", {63'h0, op_ready}, 64'h0);
    cyc(0, 0, 0, 1);

    // bubbles 1,0,0,1,1 then 4 stalled DONE cycles with a stray start
    init_val = 56'h1000; count = 8'd3;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 15'h7FFF, 0);
    cyc(0, 0, 15'h7FFF, 0);
    cyc(0, 0, 15'h7FFF, 0);
    cyc(0, 1, 15'h7FFF, 0);
    cyc(0, 1, 15'h7FFF, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 1, 1, 15'h7FFF, 0);
      chk("stall_valid", {63'h0, res_valid}, 64'h1);
      chk("stall_data", {8'h0, res_data}, 64'h18FFD);
    end
    cyc(0, 0, 0, 1);
    chk("stall_still_valid", {63'h0, res_valid}, 64'h1);
    cyc(0, 0, 0, 0);
    chk("stall_released", {63'h0, busy}, 64'h0);
    cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
